button_press_conditioner: RTL and testbench

//  Conditions a raw mechanical push-button into clean, single-cycle control events.

---
 rtl/led_ui_pkg.sv | 24 ++
 rtl/button_press_conditioner_debounce_filter.sv | 61 ++++++
 rtl/button_press_conditioner.sv | 119 +++++++++++
 tb/tb_button_press_conditioner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_ui_pkg.sv
// Package: led_ui_pkg
// Shared definitions for the LED user-interface blocks (button conditioner,
// LED shift stage and their benches).
//   state_e            : press/hold FSM state encoding
//   DEF_*_CYCLES       : default timing constants for a 27 MHz clock
//   cnt_width()        : counter width for a terminal count, never below 1 bit
package led_ui_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_e;

  localparam int DEF_DEBOUNCE_CYCLES   = 1350000;   // 50 ms @ 27 MHz
  localparam int DEF_LONG_PRESS_CYCLES = 27000000;  // 1 s
  localparam int DEF_REPEAT_CYCLES     = 5400000;   // 200 ms

  // Counters run from 0 to n-1, so $clog2(n) bits suffice for n >= 2.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/button_press_conditioner_debounce_filter.sv
// Module: debounce_filter
// Two-flop synchroniser followed by a stability filter. The debounced level
// only follows the synchronised input after it has differed for
// DEBOUNCE_CYCLES consecutive cycles; any cycle where they agree restarts
// the count, so shorter glitches never reach btn_level.
// Ports:
//   clk        in   system clock
//   RSTn       in   asynchronous active-low reset
//   btn_raw    in   asynchronous button pin
//   btn_level  out  debounced level, 1 = pressed
module debounce_filter
  import led_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic RSTn,
  input  logic btn_raw,
  output logic btn_level
);

  localparam int              DB_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            btn_in;
  logic            sync_d;
  logic            sync_q;
  logic [DB_W-1:0] db_cnt;

  // Polarity is normalised before the synchroniser so everything downstream
  // sees 1 = pressed.
  assign btn_in = BTN_ACTIVE_HIGH ? btn_raw : ~btn_raw;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sync_d <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      sync_d <= btn_in;
      sync_q <= sync_d;
    end
  end

  // Accept on the DEBOUNCE_CYCLES-th consecutive differing cycle; the count
  // is cleared on acceptance so it never runs past DB_LAST.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      btn_level <= 1'b0;
      db_cnt    <= '0;
    end else if (sync_q == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_level <= sync_q;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/button_press_conditioner.sv
// Module: button_press_conditioner
// Turns a raw push-button into single-cycle events: press, release,
// long-press and auto-repeat. step_pulse (press or repeat) drives the shift
// enable of the LED shift stage, so holding the button keeps stepping it.
// All pulse outputs are registered and appear the cycle after the event
// that causes them; at most one of press/release/long/repeat is high at once.
// Ports:
//   clk               in   system clock
//   RSTn              in   asynchronous active-low reset
//   btn_raw           in   asynchronous button pin
//   btn_level         out  debounced level, 1 = pressed
//   press_pulse       out  1-cycle pulse on accepted press
//   release_pulse     out  1-cycle pulse on accepted release
//   long_press_pulse  out  1-cycle pulse when hold reaches LONG_PRESS_CYCLES
//   repeat_pulse      out  1-cycle pulse every REPEAT_CYCLES after long-press
//   step_pulse        out  press_pulse | repeat_pulse, registered
//   state_dbg         out  current FSM state (observation only)
module button_press_conditioner
  import led_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
  parameter bit BTN_ACTIVE_HIGH   = 1'b1
) (
  input  logic   clk,
  input  logic   RSTn,
  input  logic   btn_raw,
  output logic   btn_level,
  output logic   press_pulse,
  output logic   release_pulse,
  output logic   long_press_pulse,
  output logic   repeat_pulse,
  output logic   step_pulse,
  output state_e state_dbg
);

  localparam int                HOLD_W    = cnt_width(LONG_PRESS_CYCLES);
  localparam int                REP_W     = cnt_width(REPEAT_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  state_e            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;

  debounce_filter #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_HIGH (BTN_ACTIVE_HIGH)
  ) u_debounce (
    .clk       (clk),
    .RSTn      (RSTn),
    .btn_raw   (btn_raw),
    .btn_level (btn_level)
  );

  assign state_dbg = state;

  // The release test comes first in PRESSED and HELD, so a release that
  // lands on the same cycle as a timer expiry suppresses the long/repeat
  // pulse. Counters hold at their terminal value rather than wrapping.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state            <= ST_IDLE;
      hold_cnt         <= '0;
      rep_cnt          <= '0;
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      repeat_pulse     <= 1'b0;
      step_pulse       <= 1'b0;
    end else begin
      press_pulse      <= 1'b0;
      release_pulse    <= 1'b0;
      long_press_pulse <= 1'b0;
      repeat_pulse     <= 1'b0;
      step_pulse       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (btn_level) begin
            state       <= ST_PRESSED;
            press_pulse <= 1'b1;
            step_pulse  <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        ST_PRESSED: begin
          if (!btn_level) begin
            state         <= ST_IDLE;
            release_pulse <= 1'b1;
          end else if (hold_cnt == HOLD_LAST) begin
            state            <= ST_HELD;
            long_press_pulse <= 1'b1;
            rep_cnt          <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_HELD: begin
          if (!btn_level) begin
            state         <= ST_IDLE;
            release_pulse <= 1'b1;
          end else if (rep_cnt == REP_LAST) begin
            repeat_pulse <= 1'b1;
            step_pulse   <= 1'b1;
            rep_cnt      <= '0;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        default: begin
          // Unused encoding 2'd3: fall back to IDLE without emitting events.
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_conditioner.sv
// Bench for button_press_conditioner with DEBOUNCE=4, LONG_PRESS=20,
// REPEAT=5, active-high button. Cycle n is the state sampled 1 ns after the
// n-th rising clock edge following reset release; inputs change on the
// falling edge before that rising edge.
module tb_button_press_conditioner;
  import led_ui_pkg::*;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;

  // ---------------- clock / reset ----------------
  logic   clk  = 1'b0;
  logic   rstn = 1'b0;
  logic   raw  = 1'b0;
  logic   btn_level, press_pulse, release_pulse, long_press_pulse;
  logic   repeat_pulse, step_pulse;
  state_e state_dbg;

  always #5 clk = ~clk;

  button_press_conditioner #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG),
    .REPEAT_CYCLES     (REP),
    .BTN_ACTIVE_HIGH   (1'b1)
  ) dut (
    .clk              (clk),
    .RSTn             (rstn),
    .btn_raw          (raw),
    .btn_level        (btn_level),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse),
    .repeat_pulse     (repeat_pulse),
    .step_pulse       (step_pulse),
    .state_dbg        (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic       prev_level = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] rise_q[$], press_q[$], release_q[$], long_q[$], repeat_q[$], step_q[$];

  // Table record: inputs for one cycle and the outputs expected after it,
  // packed as {btn_level, press, release, long, repeat, step}.
  typedef struct packed {
    logic       rstn;
    logic       raw;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [5:0] out_vec();
    return {btn_level, press_pulse, release_pulse, long_press_pulse, repeat_pulse, step_pulse};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic string q_str(input logic [7:0] q[$]);
    string s;
    s = "{";
    foreach (q[i]) s = $sformatf("%s %0d", s, q[i]);
    return {s, " }"};
  endfunction

  task automatic check_q(input string name, input logic [7:0] exp[$], input logic [7:0] obs[$]);
    logic ok;
    ok = (exp.size() == obs.size());
    if (ok) foreach (exp[i]) if (exp[i] !== obs[i]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got cycles %s expected cycles %s", name, q_str(obs), q_str(exp));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_vec(input logic r_n, input logic r, input logic [5:0] e);
    vec_t v;
    v.rstn = r_n;
    v.raw  = r;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // Entered and left on a falling edge.
  task automatic start_seq();
    rstn = 1'b0;
    raw  = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cyc  = 0;
    prev_level = 1'b0;
    rise_q = {}; press_q = {}; release_q = {};
    long_q = {}; repeat_q = {}; step_q = {};
  endtask

  task automatic tick(input logic r);
    raw = r;
    @(posedge clk);
    #1;
    cyc++;
    if (btn_level && !prev_level) rise_q.push_back(8'(cyc));
    prev_level = btn_level;
    if (press_pulse)      press_q.push_back(8'(cyc));
    if (release_pulse)    release_q.push_back(8'(cyc));
    if (long_press_pulse) long_q.push_back(8'(cyc));
    if (repeat_pulse)     repeat_q.push_back(8'(cyc));
    if (step_pulse)       step_q.push_back(8'(cyc));
    check_val("pulse_exclusive",
              8'($countones({press_pulse, release_pulse, long_press_pulse, repeat_pulse}) <= 1),
              8'd1);
    check_val("step_is_press_or_repeat", 8'(step_pulse), 8'(press_pulse | repeat_pulse));
    @(negedge clk);
  endtask

  // ---------------- test body ----------------
  initial begin
    // Test 1: reset held with button pressed, then release reset.
    add_vec(1'b0, 1'b1, 6'b000000);
    add_vec(1'b0, 1'b1, 6'b000000);
    for (int i = 1; i <= 5; i++) add_vec(1'b1, 1'b1, 6'b000000);
    add_vec(1'b1, 1'b1, 6'b100000);   // cycle 6: btn_level rises
    add_vec(1'b1, 1'b1, 6'b110001);   // cycle 7: press + step
    add_vec(1'b1, 1'b1, 6'b100000);
    // Test 2: 3-cycle glitch is filtered, 6-cycle press is accepted once.
    add_vec(1'b0, 1'b0, 6'b000000);
    add_vec(1'b0, 1'b0, 6'b000000);
    for (int i = 1; i <= 3; i++) add_vec(1'b1, 1'b1, 6'b000000);
    for (int i = 1; i <= 6; i++) add_vec(1'b1, 1'b0, 6'b000000);
    for (int i = 1; i <= 5; i++) add_vec(1'b1, 1'b1, 6'b000000);
    add_vec(1'b1, 1'b1, 6'b100000);   // rise at cycle 6
    add_vec(1'b1, 1'b0, 6'b110001);   // press at 7
    for (int i = 8; i <= 11; i++) add_vec(1'b1, 1'b0, 6'b100000);
    add_vec(1'b1, 1'b0, 6'b000000);   // fall at 12
    add_vec(1'b1, 1'b0, 6'b001000);   // release at 13
    add_vec(1'b1, 1'b0, 6'b000000);

    foreach (vecs[i]) begin
      rstn = vecs[i].rstn;
      raw  = vecs[i].raw;
      @(posedge clk);
      #1;
      check_val($sformatf("vec%0d_outputs", i), 8'(out_vec()), 8'(vecs[i].exp));
      @(negedge clk);
    end

    // Test 3: short press held 10 cycles.
    start_seq();
    for (int i = 1; i <= 25; i++) tick(i <= 10);
    exp_q = '{8'd6};  check_q("short_rise", exp_q, rise_q);
    exp_q = '{8'd7};  check_q("short_press", exp_q, press_q);
    exp_q = '{8'd17}; check_q("short_release", exp_q, release_q);
    exp_q = {};       check_q("short_long", exp_q, long_q);
    exp_q = {};       check_q("short_repeat", exp_q, repeat_q);
    exp_q = '{8'd7};  check_q("short_step", exp_q, step_q);

    // Test 4: long hold with auto-repeat; release lands on a repeat expiry.
    start_seq();
    for (int i = 1; i <= 55; i++) tick(i <= 40);
    exp_q = '{8'd6};                    check_q("long_rise", exp_q, rise_q);
    exp_q = '{8'd7};                    check_q("long_press", exp_q, press_q);
    exp_q = '{8'd27};                   check_q("long_longpress", exp_q, long_q);
    exp_q = '{8'd32, 8'd37, 8'd42};     check_q("long_repeat", exp_q, repeat_q);
    exp_q = '{8'd7, 8'd32, 8'd37, 8'd42}; check_q("long_step", exp_q, step_q);
    exp_q = '{8'd47};                   check_q("long_release", exp_q, release_q);

    // Test 5: release reaches the FSM on the same cycle hold_cnt is terminal.
    start_seq();
    for (int i = 1; i <= 27; i++) tick(i <= 20);
    check_val("boundary_release_now", 8'(release_pulse), 8'd1);
    check_val("boundary_state_idle", 8'(state_dbg), 8'(ST_IDLE));
    for (int i = 28; i <= 35; i++) tick(1'b0);
    exp_q = '{8'd7};  check_q("boundary_press", exp_q, press_q);
    exp_q = '{8'd27}; check_q("boundary_release", exp_q, release_q);
    exp_q = {};       check_q("boundary_long", exp_q, long_q);
    exp_q = {};       check_q("boundary_repeat", exp_q, repeat_q);
    check_val("boundary_state_end", 8'(state_dbg), 8'(ST_IDLE));

    // Test 6: asynchronous reset while HELD, on a repeat cycle.
    start_seq();
    for (int i = 1; i <= 32; i++) tick(1'b1);
    check_val("held_repeat_before_reset", 8'(repeat_pulse), 8'd1);
    check_val("held_state_before_reset", 8'(state_dbg), 8'(ST_HELD));
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_val("async_reset_outputs", 8'(out_vec()), 8'd0);
    check_val("async_reset_state", 8'(state_dbg), 8'(ST_IDLE));
    @(negedge clk);
    raw = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    cyc  = 0;
    prev_level = 1'b0;
    rise_q = {}; press_q = {}; release_q = {};
    long_q = {}; repeat_q = {}; step_q = {};
    for (int i = 1; i <= 15; i++) tick(1'b0);
    exp_q = {};
    check_q("post_reset_rise", exp_q, rise_q);
    check_q("post_reset_press", exp_q, press_q);
    check_q("post_reset_release", exp_q, release_q);
    check_q("post_reset_step", exp_q, step_q);
    check_val("post_reset_level", 8'(btn_level), 8'd0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
